inv_sub_byte_iter: RTL



---
 rtl/inv_sub_byte_iter_pkg.sv | 19 +
 rtl/inv_sbox.sv | 34 +++
 rtl/inv_sub_byte_iter.sv | 107 ++++++++++
 3 files changed

// File: rtl/inv_sub_byte_iter_pkg.sv
// Shared widths, FSM encoding and sizing helpers for the iterative InvSubBytes block.
package inv_sub_byte_iter_pkg;

   localparam int unsigned STATE_W   = 128;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned NUM_BYTES = STATE_W / BYTE_W;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   // Counter width for n states; a single-state counter still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box. The byte is split into row (high nibble) and
// column (low nibble), matching the forward S-box port order.
module inv_sbox
   import inv_sub_byte_iter_pkg::*;
(
   input  logic [3:0]        row_i,
   input  logic [3:0]        col_i,
   output logic [BYTE_W-1:0] out_o
);

   // One entry per row; column 0 sits in the most significant byte of each literal.
   localparam logic [15:0][BYTE_W-1:0] InvTbl [16] = '{
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // Column c lives at packed byte 15-c, which is the bitwise complement of c.
   assign out_o = InvTbl[row_i][~col_i];

endmodule

// File: rtl/inv_sub_byte_iter.sv
// Iterative AES InvSubBytes: accepts one 128-bit state, substitutes BYTES_PER_CYCLE
// bytes per cycle through shared inverse S-boxes (lowest byte first) and presents the
// result until the consumer takes it.
module inv_sub_byte_iter
   import inv_sub_byte_iter_pkg::*;
#(
   parameter int unsigned BYTES_PER_CYCLE = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [STATE_W-1:0] in_state_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [STATE_W-1:0] out_state_o,
   output logic               busy_o
);

   localparam int unsigned NUM_STEPS = NUM_BYTES / BYTES_PER_CYCLE;
   localparam int unsigned StepW     = cnt_width(NUM_STEPS);
   localparam int unsigned IdxW      = $clog2(NUM_BYTES);
   localparam logic [StepW-1:0] LastStep = StepW'(NUM_STEPS - 1);

   state_e                             state_q;
   logic [StepW-1:0]                   step_q;
   logic [NUM_BYTES-1:0][BYTE_W-1:0]   work_q;
   logic [NUM_BYTES-1:0][BYTE_W-1:0]   work_d;
   logic                               out_valid_q;
   logic                               busy_q;

   logic [IdxW-1:0]   base_idx;
   logic [IdxW-1:0]   byte_idx [BYTES_PER_CYCLE];
   logic [BYTE_W-1:0] sbox_out [BYTES_PER_CYCLE];

   // First byte handled this step; legal parameters keep this inside 0..15.
   assign base_idx = IdxW'(32'(step_q) * BYTES_PER_CYCLE);

   for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
      assign byte_idx[g] = base_idx + IdxW'(g);

      inv_sbox u_inv_sbox (
         .row_i (work_q[byte_idx[g]][7:4]),
         .col_i (work_q[byte_idx[g]][3:0]),
         .out_o (sbox_out[g])
      );
   end

   // Work register with the current step's bytes replaced by their substitutes.
   always_comb begin
      work_d = work_q;
      for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
         work_d[byte_idx[i]] = sbox_out[i];
      end
   end

   // Control FSM plus datapath registers; reset aborts any block in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         step_q      <= '0;
         work_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid_i && in_ready_o) begin
                  work_q  <= in_state_i;
                  step_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               work_q <= work_d;
               if (step_q == LastStep) begin
                  step_q      <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  step_q <= step_q + StepW'(1);
               end
            end
            StDone: begin
               // Result is held until taken; no pass-through to a new block.
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = out_valid_q;
   assign out_state_o = work_q;
   assign busy_o      = busy_q;

endmodule
